cc_unit: RTL and testbench
==========================

# cc_unit

Parametrised condition-code unit for the multi-context datapath. It holds NUM_CTX independent N/Z/P flag sets, each loaded from the global bus at a configurable WIDTH. It evaluates the branch-enable (BEN) condition against an instruction's nzp field and provides a shared LIFO save/restore stack for interrupt entry and RTI. It sits beside the register file and feeds the control FSM's branch decision.

## Interface
- WIDTH, 16, data width of Global_Bus; sign bit is WIDTH-1
- NUM_CTX, 4, number of independent flag contexts (≥2)
- STACK_DEPTH, 4, entries in the save/restore LIFO (≥1)
- Clk  in  1  sole clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Global_Bus  in  WIDTH  value whose sign/zero status is captured
- LD_CC  in  1  load flags of context Ctx_Sel from Global_Bus
- Ctx_Sel  in  $clog2(NUM_CTX)  context addressed by all operations and outputs
- IR_NZP  in  3  {n,z,p} condition field of current branch instruction
- LD_BEN  in  1  register BEN from IR_NZP and selected context's flags
- Save_CC  in  1  push selected context's flags onto stack
- Restore_CC  in  1  pop stack top into selected context's flags
- Clr_Err  in  1  clear Stack_Err
- N, Z, P  out  1 each  flags of context Ctx_Sel (combinational mux of registered state)
- BEN  out  1  registered branch enable
- Stack_Full  out  1  stack holds STACK_DEPTH entries
- Stack_Empty  out  1  stack holds 0 entries
- Stack_Err  out  1  sticky: overflow, underflow or Save/Restore collision

## Operation
- Flag encoding: bus[WIDTH-1]=1 → 100; bus==0 → 010; otherwise → 001. Exactly one flag is set at all times.
- Reset: every context = 010, BEN=0, stack count=0, Stack_Empty=1, Stack_Full=0, Stack_Err=0. Stack contents are don't-care.
- LD_CC: context[Ctx_Sel] ← encoding of Global_Bus at the edge. Other contexts hold.
- LD_BEN: BEN ← |(IR_NZP & {N,Z,P}), using flags before any same-edge update. BEN holds otherwise.
- Save_CC, stack not full: push context[Ctx_Sel]; count+1. Pushes the pre-update value when LD_CC is asserted in the same cycle; LD_CC still applies.
- Save_CC, stack full: no push, count unchanged, Stack_Err ← 1. LD_CC still applies.
- Restore_CC, stack not empty: context[Ctx_Sel] ← top; count−1. Restore overrides a simultaneous LD_CC.
- Restore_CC, stack empty: flags unchanged; a simultaneous LD_CC applies; Stack_Err ← 1.
- Save_CC and Restore_CC together: neither takes effect, Stack_Err ← 1. LD_CC applies.
- Clr_Err: Stack_Err ← 0, unless a new error occurs in the same cycle (set wins).
- Out-of-range Ctx_Sel (NUM_CTX not a power of 2): all writes ignored; N/Z/P read 000.

## Timing
- All state updates occur on the rising edge of Clk. Reset_n low clears state immediately, independent of Clk.
- N/Z/P reflect a load one cycle after LD_CC; they change combinationally with Ctx_Sel.
- BEN has 1-cycle latency from LD_BEN.
- Stack_Full/Stack_Empty are decoded from the registered count, so they are valid the cycle after a push or pop.
- Reset mid-sequence discards all stacked entries; the stack is not preserved.

## Structure
- Package cc_pkg:
  - typedef struct packed {n,z,p} nzp_t
  - constant CC_RESET = 3'b010
  - function nzp_of(bus) producing nzp_t (WIDTH passed as a parameter of a parametrised class or as a localparam in the unit)
- Sub-module cc_stack: parametrised LIFO of nzp_t, depth STACK_DEPTH. Ports: push, pop, din, dout, full, empty, overflow, underflow. cc_unit owns the collision and error policy.
- The context bank is an array of nzp_t inside cc_unit.

## Test plan
- Reset, then load per context: hold Reset_n low, then load bus 0x8000 into ctx 0, 0x0000 into ctx 1, 0x0005 into ctx 2 → ctx0 NZP=100, ctx1=010, ctx2=001, ctx3 still 010.
- BEN with same-edge update: ctx0=001, IR_NZP=001, LD_BEN with LD_CC of 0xFFFF on the same edge → BEN=1 (old flags used); next cycle NZP=100.
- Save/restore round trip: ctx2=001, Save; load 0x0000; Restore → NZP=001, Stack_Empty=1, Stack_Err=0.
- Overflow: with STACK_DEPTH=4, issue 5 Saves → Stack_Full=1, Stack_Err=1 after the 5th. Then 4 Restores return entries in LIFO order.
- Underflow plus collision: Restore on an empty stack → Stack_Err=1, flags unchanged. Clr_Err → 0. Save+Restore on one edge → count unchanged, Stack_Err=1.
- Asynchronous reset mid-operation: 2 entries stacked, ctx1=100, pulse Reset_n low between clock edges → immediate NZP=010, Stack_Empty=1, BEN=0.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared types and helpers for the condition-code unit.
package cc_pkg;

  // One flag set; exactly one of n/z/p is set in any valid state.
  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  localparam nzp_t CC_RESET = 3'b010;
  localparam nzp_t CC_NONE  = 3'b000;

  // Widest bus nzp_of can classify; callers zero-extend narrower buses.
  localparam int unsigned CC_BUS_MAX = 64;

  // Classify a bus value of the given width as negative, zero or positive.
  function automatic nzp_t nzp_of(input logic [CC_BUS_MAX-1:0] bus,
                                  input int unsigned width);
    logic [CC_BUS_MAX-1:0] shifted;
    nzp_t r;
    shifted = bus >> (width - 1);
    r = CC_NONE;
    if (shifted[0]) begin
      r.n = 1'b1;
    end else if (bus == '0) begin
      r.z = 1'b1;
    end else begin
      r.p = 1'b1;
    end
    return r;
  endfunction

  // Branch enable: any condition bit requested by the instruction is set.
  function automatic logic ben_of(input logic [2:0] mask, input nzp_t cc);
    return |(mask & cc);
  endfunction

endpackage

// File: rtl/cc_stack.sv
// LIFO of flag sets used for interrupt entry / RTI save-restore.
// Push and pop are self-protecting: a push when full or a pop when empty
// does nothing to the stack and is reported on overflow/underflow.
module cc_stack
  import cc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  nzp_t din,
  output nzp_t dout,
  output logic full,
  output logic empty,
  output logic overflow,
  output logic underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] count;
  nzp_t          mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          push_only;
  logic          pop_only;

  // Status decode and index generation from the registered count.
  always_comb begin
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    overflow  = push & full;
    underflow = pop & empty;
    push_only = push & ~full & ~pop;
    pop_only  = pop & ~empty & ~push;
    wr_idx    = IW'(count);
    rd_idx    = IW'(count - CW'(1));
    dout      = empty ? CC_RESET : mem[rd_idx];
  end

  // Occupancy counter; reset discards every stacked entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push_only) begin
      count <= count + CW'(1);
    end else if (pop_only) begin
      count <= count - CW'(1);
    end
  end

  // Entry storage; contents are meaningless while not counted.
  always_ff @(posedge clk) begin
    if (push_only) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/cc_unit.sv
// Multi-context condition-code unit: per-context N/Z/P flags, registered
// branch enable, and a shared save/restore stack with sticky error flag.
module cc_unit
  import cc_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned NUM_CTX     = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [WIDTH-1:0]           Global_Bus,
  input  logic                       LD_CC,
  input  logic [$clog2(NUM_CTX)-1:0] Ctx_Sel,
  input  logic [2:0]                 IR_NZP,
  input  logic                       LD_BEN,
  input  logic                       Save_CC,
  input  logic                       Restore_CC,
  input  logic                       Clr_Err,
  output logic                       N,
  output logic                       Z,
  output logic                       P,
  output logic                       BEN,
  output logic                       Stack_Full,
  output logic                       Stack_Empty,
  output logic                       Stack_Err
);

  localparam int unsigned SW = $clog2(NUM_CTX);

  nzp_t ctx [NUM_CTX];
  nzp_t cur_cc;
  nzp_t load_cc;
  nzp_t top_cc;
  nzp_t ctx_wdata;
  logic ctx_ok;
  logic ctx_we;
  logic save_req;
  logic restore_req;
  logic collide;
  logic push;
  logic pop;
  logic restore_hit;
  logic overflow;
  logic underflow;
  logic err_set;

  // A selector beyond NUM_CTX can only occur when NUM_CTX is not a power of 2.
  if (NUM_CTX == (2 ** SW)) begin : g_sel_full
    assign ctx_ok = 1'b1;
  end else begin : g_sel_part
    assign ctx_ok = (Ctx_Sel < SW'(NUM_CTX));
  end

  // Request decode: Save+Restore together cancel each other and only flag an error.
  always_comb begin
    save_req    = Save_CC & ctx_ok;
    restore_req = Restore_CC & ctx_ok;
    collide     = save_req & restore_req;
    push        = save_req & ~restore_req;
    pop         = restore_req & ~save_req;
    restore_hit = pop & ~Stack_Empty;
    err_set     = collide | overflow | underflow;
  end

  // Selected context read and the next value to write into it.
  always_comb begin
    cur_cc    = ctx_ok ? ctx[Ctx_Sel] : CC_NONE;
    load_cc   = nzp_of(CC_BUS_MAX'(Global_Bus), WIDTH);
    ctx_we    = ctx_ok & (restore_hit | LD_CC);
    ctx_wdata = restore_hit ? top_cc : load_cc;
    N         = cur_cc.n;
    Z         = cur_cc.z;
    P         = cur_cc.p;
  end

  cc_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (push),
    .pop       (pop),
    .din       (cur_cc),
    .dout      (top_cc),
    .full      (Stack_Full),
    .empty     (Stack_Empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Context bank: restore takes priority over a same-edge bus load.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NUM_CTX; i++) begin
        ctx[i] <= CC_RESET;
      end
    end else if (ctx_we) begin
      ctx[Ctx_Sel] <= ctx_wdata;
    end
  end

  // Branch enable samples the flags as they were before this edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      BEN <= 1'b0;
    end else if (LD_BEN) begin
      BEN <= ben_of(IR_NZP, cur_cc);
    end
  end

  // Sticky stack error; a new error wins over a same-cycle clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Stack_Err <= 1'b0;
    end else if (err_set) begin
      Stack_Err <= 1'b1;
    end else if (Clr_Err) begin
      Stack_Err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cc_unit.sv
// Self-checking bench for cc_unit against a queue-based reference model.
`timescale 1ns/100ps
module tb_cc_unit;

  localparam int W  = 16;
  localparam int NC = 4;
  localparam int SD = 4;

  logic          Clk;
  logic          Reset_n;
  logic [W-1:0]  Global_Bus;
  logic          LD_CC;
  logic [1:0]    Ctx_Sel;
  logic [2:0]    IR_NZP;
  logic          LD_BEN;
  logic          Save_CC;
  logic          Restore_CC;
  logic          Clr_Err;
  logic          N, Z, P, BEN, Stack_Full, Stack_Empty, Stack_Err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [2:0] mctx [NC];
  logic [2:0] mq [$];
  logic       mben;
  logic       merr;

  cc_unit #(
    .WIDTH       (W),
    .NUM_CTX     (NC),
    .STACK_DEPTH (SD)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Global_Bus  (Global_Bus),
    .LD_CC       (LD_CC),
    .Ctx_Sel     (Ctx_Sel),
    .IR_NZP      (IR_NZP),
    .LD_BEN      (LD_BEN),
    .Save_CC     (Save_CC),
    .Restore_CC  (Restore_CC),
    .Clr_Err     (Clr_Err),
    .N           (N),
    .Z           (Z),
    .P           (P),
    .BEN         (BEN),
    .Stack_Full  (Stack_Full),
    .Stack_Empty (Stack_Empty),
    .Stack_Err   (Stack_Err)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] enc(input logic [W-1:0] b);
    if (b[W-1]) return 3'b100;
    if (b == '0) return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) mctx[i] = 3'b010;
    mq.delete();
    mben = 1'b0;
    merr = 1'b0;
  endtask

  // Apply one clock edge's worth of the behavioural rules to the model.
  task automatic model_edge();
    logic [2:0] cur;
    logic       e;
    cur = mctx[Ctx_Sel];
    e   = 1'b0;
    if (LD_BEN) mben = |(IR_NZP & cur);
    if (Save_CC && Restore_CC) begin
      e = 1'b1;
      if (LD_CC) mctx[Ctx_Sel] = enc(Global_Bus);
    end else if (Save_CC) begin
      if (mq.size() < SD) mq.push_back(cur);
      else e = 1'b1;
      if (LD_CC) mctx[Ctx_Sel] = enc(Global_Bus);
    end else if (Restore_CC) begin
      if (mq.size() > 0) mctx[Ctx_Sel] = mq.pop_back();
      else begin
        e = 1'b1;
        if (LD_CC) mctx[Ctx_Sel] = enc(Global_Bus);
      end
    end else if (LD_CC) begin
      mctx[Ctx_Sel] = enc(Global_Bus);
    end
    if (e) merr = 1'b1;
    else if (Clr_Err) merr = 1'b0;
  endtask

  task automatic compare_all();
    check("ben",   32'(BEN),         32'(mben));
    check("full",  32'(Stack_Full),  32'(mq.size() == SD));
    check("empty", 32'(Stack_Empty), 32'(mq.size() == 0));
    check("err",   32'(Stack_Err),   32'(merr));
    for (int i = 0; i < NC; i++) begin
      Ctx_Sel = 2'(i);
      #1;
      check($sformatf("nzp%0d", i), 32'({N, Z, P}), 32'(mctx[i]));
    end
  endtask

  task automatic idle();
    LD_CC = 0; LD_BEN = 0; Save_CC = 0; Restore_CC = 0; Clr_Err = 0;
  endtask

  task automatic step(input logic ld, input logic [1:0] sel, input logic [W-1:0] bus,
                      input logic [2:0] ir, input logic lb, input logic sv,
                      input logic rs, input logic cl);
    LD_CC = ld; Ctx_Sel = sel; Global_Bus = bus; IR_NZP = ir;
    LD_BEN = lb; Save_CC = sv; Restore_CC = rs; Clr_Err = cl;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    idle();
    compare_all();
  endtask

  task automatic peek(input string tag, input logic [1:0] sel, input logic [2:0] exp);
    Ctx_Sel = sel;
    #1;
    check(tag, 32'({N, Z, P}), 32'(exp));
  endtask

  // Pulse reset between edges and confirm it acts without a clock.
  task automatic async_reset();
    #1 Reset_n = 1'b0;
    #1;
    check("ar_empty", 32'(Stack_Empty), 32'd1);
    check("ar_ben",   32'(BEN),         32'd0);
    check("ar_err",   32'(Stack_Err),   32'd0);
    peek("ar_nzp1", 2'd1, 3'b010);
    model_reset();
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    Global_Bus = '0; Ctx_Sel = '0; IR_NZP = '0;
    idle();
    model_reset();
    repeat (2) @(negedge Clk);
    compare_all();
    check("rst_empty", 32'(Stack_Empty), 32'd1);
    peek("rst_nzp3", 2'd3, 3'b010);
    Reset_n = 1'b1;

    // Per-context loads
    step(1, 0, 16'h8000, 0, 0, 0, 0, 0);
    step(1, 1, 16'h0000, 0, 0, 0, 0, 0);
    step(1, 2, 16'h0005, 0, 0, 0, 0, 0);
    peek("ld_ctx0", 0, 3'b100);
    peek("ld_ctx1", 1, 3'b010);
    peek("ld_ctx2", 2, 3'b001);
    peek("ld_ctx3", 3, 3'b010);

    // BEN uses flags from before a same-edge load
    step(1, 0, 16'h0005, 0, 0, 0, 0, 0);
    step(1, 0, 16'hFFFF, 3'b001, 1, 0, 0, 0);
    check("ben_old", 32'(BEN), 32'd1);
    peek("ben_new", 0, 3'b100);

    // Save / restore round trip
    step(0, 2, 0, 0, 0, 1, 0, 0);
    step(1, 2, 16'h0000, 0, 0, 0, 0, 0);
    step(0, 2, 0, 0, 0, 0, 1, 0);
    peek("rt_nzp", 2, 3'b001);
    check("rt_empty", 32'(Stack_Empty), 32'd1);
    check("rt_err",   32'(Stack_Err),   32'd0);

    // Overflow, with pushes taking the pre-load value
    step(1, 0, 16'h8000, 0, 0, 1, 0, 0);
    step(1, 0, 16'h0000, 0, 0, 1, 0, 0);
    step(1, 0, 16'h0005, 0, 0, 1, 0, 0);
    step(1, 0, 16'hFFFF, 0, 0, 1, 0, 0);
    check("ov_err0", 32'(Stack_Err), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check("ov_full", 32'(Stack_Full), 32'd1);
    check("ov_err",  32'(Stack_Err),  32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0); peek("lifo0", 0, 3'b001);
    step(0, 0, 0, 0, 0, 0, 1, 0); peek("lifo1", 0, 3'b010);
    step(0, 0, 0, 0, 0, 0, 1, 0); peek("lifo2", 0, 3'b100);
    step(0, 0, 0, 0, 0, 0, 1, 0); peek("lifo3", 0, 3'b100);

    // Underflow, clear, collision
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("clr0", 32'(Stack_Err), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("uf_err", 32'(Stack_Err), 32'd1);
    peek("uf_nzp", 0, 3'b100);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("clr1", 32'(Stack_Err), 32'd0);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    check("col_err",   32'(Stack_Err),   32'd1);
    check("col_empty", 32'(Stack_Empty), 32'd1);

    // Asynchronous reset mid-operation
    step(0, 1, 0, 0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 16'h8000, 0, 0, 0, 0, 0);
    step(0, 1, 0, 3'b100, 1, 0, 0, 0);
    check("pre_ben", 32'(BEN), 32'd1);
    async_reset();

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      logic [W-1:0] bus;
      case ($urandom_range(0, 3))
        0:       bus = '0;
        1:       bus = W'($urandom) | 16'h8000;
        default: bus = W'($urandom) & 16'h7FFF;
      endcase
      step(1'($urandom), 2'($urandom), bus, 3'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0));
      if (it % 200 == 199) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
